// File: rtl/store_buffer.sv
// Store buffer in front of a single-port data memory: queues stores and drains them when no load needs the port.
// Define STORE_BUF_FWD_EN to forward buffered data to loads; when undefined, matching loads stall until drained.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int CMP_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    st_valid,
   input  logic [ADDR_W-1:0]       st_addr,
   input  logic [DATA_W-1:0]       st_data,
   input  logic                    ld_valid,
   input  logic [ADDR_W-1:0]       ld_addr,
   output logic [DATA_W-1:0]       ld_data,
   output logic                    stall,
   input  logic                    flush,
   output logic                    flush_done,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_write_data,
   output logic                    mem_write_en,
   input  logic [DATA_W-1:0]       mem_read_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic              flush_done_q, flush_done_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [DEPTH-1:0]  hit;
   logic              ld_block;
   logic              drain;
   logic              enq;
   logic              full;

   // Address match per physical slot; only the low CMP_W bits index the memory.
   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = valid_q[i] && (addr_q[i][CMP_W-1:0] == ld_addr[CMP_W-1:0]);
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [PTR_W-1:0]  idx;
   logic [DATA_W-1:0] fwd_data;

   // Walk from oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      fwd_data = mem_read_data;
      idx      = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (hit[idx]) fwd_data = data_q[idx];
      end
   end

   assign ld_data  = fwd_data;
   assign ld_block = 1'b0;
`else
   assign ld_data  = mem_read_data;
   assign ld_block = ld_valid && (|hit);
`endif

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      head_d         = head_q;
      tail_d         = tail_q;
      valid_d        = valid_q;
      flush_done_d   = 1'b0;
      stall          = 1'b0;
      drain          = 1'b0;
      enq            = 1'b0;
      mem_addr       = addr_q[head_q];
      mem_write_data = data_q[head_q];
      full           = (count_q == CNT_W'(DEPTH));

      case (state_q)
         S_RUN: begin
            // A blocked load implies a valid entry exists, so draining is always legal here.
            if (ld_block) begin
               stall = 1'b1;
               drain = 1'b1;
            end else if (ld_valid) begin
               mem_addr = ld_addr;
            end else begin
               drain = (count_q != '0);
            end
            if (st_valid && full && !drain) stall = 1'b1;
            enq = st_valid && !stall;
         end
         S_FLUSH: begin
            stall = ld_valid || st_valid;
            drain = (count_q != '0);
         end
         default: ;
      endcase

      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain);

      if (state_q == S_RUN && flush) begin
         if (count_d == '0) flush_done_d = 1'b1;
         else               state_d      = S_FLUSH;
      end
      if (state_q == S_FLUSH && count_d == '0) begin
         state_d      = S_RUN;
         flush_done_d = 1'b1;
      end

      // Queued stores are discarded on reset, never written out.
      mem_write_en = drain && !rst;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RUN;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         valid_q      <= valid_d;
         flush_done_q <= flush_done_d;
      end
   end

   // NOTE: entry payload is not reset; the valid bits alone decide whether a slot means anything.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
      end
   end

   assign count      = count_q;
   assign flush_done = flush_done_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small 256-word data memory on the shared port.
// Expectations follow the build: STORE_BUF_FWD_EN selects forwarding, otherwise matching loads stall.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [15:0] st_addr;
   logic [15:0] st_data;
   logic        ld_valid;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;
   logic        stall;
   logic        flush;
   logic        flush_done;
   logic [15:0] mem_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic [15:0] mem_read_data;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem [256];
   logic        mem_clr;

   store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16), .CMP_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .st_valid       (st_valid),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .ld_valid       (ld_valid),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .stall          (stall),
      .flush          (flush),
      .flush_done     (flush_done),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en),
      .mem_read_data  (mem_read_data),
      .count          (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_write_en) begin
         mem[mem_addr[7:0]] <= mem_write_data;
      end
   end

   assign mem_read_data = mem[mem_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [15:0] sa, input logic [15:0] sd,
                        input logic ld, input logic [15:0] la, input logic fl);
      st_valid = st;
      st_addr  = sa;
      st_data  = sd;
      ld_valid = ld;
      ld_addr  = la;
      flush    = fl;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      mem_clr = 1'b1;
      idle();
      step();
      step();
      rst     = 1'b0;
      mem_clr = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_stall", stall, 0);
      check("rst_we", mem_write_en, 0);
      check("rst_fdone", flush_done, 0);

      // 1: single store drains next cycle, then reads back from memory
      drive(1'b1, 16'h0010, 16'hAAAA, 1'b0, 16'h0, 1'b0); #1;
      check("t1_stall", stall, 0);
      check("t1_we_enq", mem_write_en, 0);
      step();
      idle(); #1;
      check("t1_count", count, 1);
      check("t1_we", mem_write_en, 1);
      check("t1_addr", mem_addr, 16'h0010);
      check("t1_wdata", mem_write_data, 16'hAAAA);
      step();
      check("t1_empty", count, 0);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0); #1;
      check("t1_ld", ld_data, 16'hAAAA);
      check("t1_ld_stall", stall, 0);
      step();

      // 2: two stores to the same low address, then an aliasing load
      drive(1'b1, 16'h0005, 16'h1111, 1'b1, 16'h0050, 1'b0); #1;
      check("t2_s0_stall", stall, 0);
      step();
      drive(1'b1, 16'h0005, 16'h2222, 1'b1, 16'h0050, 1'b0); #1;
      check("t2_s1_stall", stall, 0);
      check("t2_s1_we", mem_write_en, 0);
      step();
      check("t2_count", count, 2);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0105, 1'b0); #1;
`ifdef STORE_BUF_FWD_EN
      check("t2_fwd_data", ld_data, 16'h2222);
      check("t2_fwd_stall", stall, 0);
      check("t2_fwd_we", mem_write_en, 0);
      step();
      idle();
      step();
      step();
`else
      check("t2_blk_stall0", stall, 1);
      check("t2_blk_we0", mem_write_en, 1);
      check("t2_blk_wd0", mem_write_data, 16'h1111);
      step();
      check("t2_blk_stall1", stall, 1);
      check("t2_blk_wd1", mem_write_data, 16'h2222);
      step();
      check("t2_blk_release", stall, 0);
      check("t2_blk_data", ld_data, 16'h2222);
      step();
      idle();
`endif
      #1;
      check("t2_drained", count, 0);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0005, 1'b0); #1;
      check("t2_mem", ld_data, 16'h2222);
      step();

      // 3: fill to DEPTH under load pressure, overflow store stalls, then enqueues with a drain
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0020 + 16'(i), 16'h3000 + 16'(i), 1'b1, 16'h0080, 1'b0); #1;
         check("t3_fill_stall", stall, 0);
         step();
      end
      drive(1'b1, 16'h0024, 16'h3004, 1'b1, 16'h0080, 1'b0); #1;
      check("t3_full_stall", stall, 1);
      check("t3_full_count", count, 4);
      step();
      check("t3_held_count", count, 4);
      drive(1'b1, 16'h0024, 16'h3004, 1'b0, 16'h0, 1'b0); #1;
      check("t3_swap_stall", stall, 0);
      check("t3_swap_addr", mem_addr, 16'h0020);
      step();
      check("t3_swap_count", count, 4);
      idle();
      for (int i = 1; i < 5; i++) begin
         #1;
         check("t3_drain_addr", mem_addr, 16'h0020 + 16'(i));
         check("t3_drain_data", mem_write_data, 16'h3000 + 16'(i));
         step();
      end
      check("t3_empty", count, 0);

      // 4: ten back-to-back stores wrap the pointers and drain in order
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 16'(i), 16'h0100 + 16'(i), 1'b0, 16'h0, 1'b0); #1;
         check("t4_stall", stall, 0);
         if (i > 0) begin
            check("t4_count", count, 1);
            check("t4_we", mem_write_en, 1);
            check("t4_addr", mem_addr, 16'(i - 1));
            check("t4_data", mem_write_data, 16'h0100 + 16'(i - 1));
         end else begin
            check("t4_we_first", mem_write_en, 0);
         end
         step();
      end
      idle(); #1;
      check("t4_last_addr", mem_addr, 16'h0009);
      check("t4_last_data", mem_write_data, 16'h0109);
      step();
      check("t4_empty", count, 0);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 1'b0); #1;
      check("t4_mem", ld_data, 16'h0103);
      step();

      // 5: flush three entries, then flush an empty buffer
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0030 + 16'(i), 16'h5000 + 16'(i), 1'b1, 16'h0090, 1'b0); #1;
         step();
      end
      check("t5_count", count, 3);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); #1;
      check("t5_d0_we", mem_write_en, 1);
      check("t5_d0_addr", mem_addr, 16'h0030);
      check("t5_d0_fdone", flush_done, 0);
      step();
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0090, 1'b0); #1;
      check("t5_d1_stall", stall, 1);
      check("t5_d1_addr", mem_addr, 16'h0031);
      check("t5_d1_count", count, 2);
      step();
      check("t5_d2_stall", stall, 1);
      check("t5_d2_addr", mem_addr, 16'h0032);
      check("t5_d2_fdone", flush_done, 0);
      step();
      idle(); #1;
      check("t5_fdone", flush_done, 1);
      check("t5_fcount", count, 0);
      check("t5_fwe", mem_write_en, 0);
      step();
      check("t5_fdone_pulse", flush_done, 0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); #1;
      check("t5e_fdone_now", flush_done, 0);
      step();
      idle(); #1;
      check("t5e_fdone", flush_done, 1);
      step();
      check("t5e_fdone_pulse", flush_done, 0);

      // 6: reset while flushing two entries discards them without writes
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'h0040 + 16'(i), 16'h6000 + 16'(i), 1'b1, 16'h0090, 1'b0); #1;
         step();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0090, 1'b1); #1;
      check("t6_pulse_we", mem_write_en, 0);
      step();
      check("t6_count", count, 2);
      idle();
      rst = 1'b1; #1;
      check("t6_rst_we", mem_write_en, 0);
      step();
      rst = 1'b0; #1;
      check("t6_count0", count, 0);
      check("t6_fdone", flush_done, 0);
      for (int i = 0; i < 3; i++) begin
         check("t6_no_we", mem_write_en, 0);
         step();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0040, 1'b0); #1;
      check("t6_mem_untouched", ld_data, 16'h0000);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
